// File: rtl/game_pkg.sv
// Shared command codes, state-image field offsets and grid geometry for the
// box-pushing game state keeper.
package game_pkg;

   typedef enum logic [1:0] {
      SEL_LOAD    = 2'd0,
      SEL_MOVE    = 2'd1,
      SEL_RSVD    = 2'd2,
      SEL_RETRACT = 2'd3
   } sel_e;

   localparam int STATE_W = 134;
   localparam int WAY_HI  = 133;
   localparam int WAY_LO  = 70;
   localparam int BOX_HI  = 69;
   localparam int BOX_LO  = 6;
   localparam int POS_HI  = 5;
   localparam int POS_LO  = 0;
   localparam int GRID_W  = 8;

endpackage

// File: rtl/state_history.sv
// Ring-buffer LIFO of prior game images; a push onto a full ring silently
// overwrites the oldest entry so the most recent DEPTH moves stay retractable.
module state_history #(
   parameter int DEPTH = 8,
   parameter int W     = 134
) (
   input  logic         clk,
   input  logic         reset,
   input  logic         push_i,
   input  logic         pop_i,
   input  logic         clear_i,
   input  logic [W-1:0] push_data_i,
   output logic [W-1:0] top_data_o,
   output logic [4:0]   count_o
);

   localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

   logic [W-1:0]     mem_q [DEPTH];
   logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
   logic [4:0]       count_q, count_d;

   always_comb begin
      wr_ptr_d = wr_ptr_q;
      count_d  = count_q;
      if (clear_i) begin
         wr_ptr_d = '0;
         count_d  = '0;
      end else if (push_i) begin
         wr_ptr_d = wr_ptr_q + PTR_W'(1);
         if (count_q != 5'(DEPTH)) count_d = count_q + 5'd1;
      end else if (pop_i && count_q != 5'd0) begin
         wr_ptr_d = wr_ptr_q - PTR_W'(1);
         count_d  = count_q - 5'd1;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         wr_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         count_q  <= count_d;
      end
   end

   // Storage is left unreset; count gates every read of it.
   always_ff @(posedge clk) begin
      if (push_i && !clear_i) mem_q[wr_ptr_q] <= push_data_i;
   end

   assign top_data_o = mem_q[wr_ptr_q - PTR_W'(1)];
   assign count_o    = count_q;

endmodule

// File: rtl/game_state_keeper.sv
// Holds the current game image, judges walk/push legality of the cursor cell,
// and applies LOAD / MOVE / RETRACT commands with a bounded undo history.
module game_state_keeper
   import game_pkg::*;
#(
   parameter int HIST_DEPTH = 8,
   parameter int STEP_W     = 10
) (
   input  logic                clk,
   input  logic                reset,
   input  logic                game_state_en,
   input  logic [1:0]          sel,
   input  logic [5:0]          cursor,
   input  logic [STATE_W-1:0]  init_state,
   output logic [STATE_W-1:0]  game_state,
   output logic                move_result,
   output logic [STEP_W-1:0]   step_count,
   output logic [4:0]          hist_count
);

   logic [STATE_W-1:0] state_q, state_d;
   logic [STEP_W-1:0]  step_q, step_d;
   logic [STATE_W-1:0] hist_top;
   logic               h_push, h_pop, h_clear;

   logic [63:0] way, box, box_n;
   logic [5:0]  pos, beyond;
   logic        up_adj, dn_adj, lf_adj, rt_adj, adj, beyond_ok;
   logic        walk_ok, push_ok;

   localparam logic [5:0] ROW = 6'(GRID_W);

   always_comb begin
      way = state_q[WAY_HI:WAY_LO];
      box = state_q[BOX_HI:BOX_LO];
      pos = state_q[POS_HI:POS_LO];

      up_adj = (pos >= ROW)       && (cursor == pos - ROW);
      dn_adj = (pos < 6'd56)      && (cursor == pos + ROW);
      lf_adj = (pos[2:0] != 3'd0) && (cursor == pos - 6'd1);
      rt_adj = (pos[2:0] != 3'd7) && (cursor == pos + 6'd1);
      adj    = up_adj | dn_adj | lf_adj | rt_adj;

      // The beyond cell continues the same direction and must not leave the grid.
      beyond    = cursor;
      beyond_ok = 1'b0;
      if (up_adj) begin
         beyond    = cursor - ROW;
         beyond_ok = cursor >= ROW;
      end else if (dn_adj) begin
         beyond    = cursor + ROW;
         beyond_ok = cursor < 6'd56;
      end else if (lf_adj) begin
         beyond    = cursor - 6'd1;
         beyond_ok = cursor[2:0] != 3'd0;
      end else if (rt_adj) begin
         beyond    = cursor + 6'd1;
         beyond_ok = cursor[2:0] != 3'd7;
      end

      walk_ok = adj && way[cursor] && !box[cursor];
      push_ok = adj && box[cursor] && beyond_ok && way[beyond] && !box[beyond];
      move_result = walk_ok | push_ok;
   end

   always_comb begin
      state_d = state_q;
      step_d  = step_q;
      h_push  = 1'b0;
      h_pop   = 1'b0;
      h_clear = 1'b0;
      box_n   = box;
      if (game_state_en) begin
         case (sel_e'(sel))
            SEL_LOAD: begin
               state_d = init_state;
               step_d  = '0;
               h_clear = 1'b1;
            end
            SEL_MOVE: begin
               if (move_result) begin
                  h_push = 1'b1;
                  if (push_ok) begin
                     box_n[cursor] = 1'b0;
                     box_n[beyond] = 1'b1;
                  end
                  state_d = {way, box_n, cursor};
                  if (step_q != '1) step_d = step_q + STEP_W'(1);
               end
            end
            SEL_RETRACT: begin
               if (hist_count != 5'd0) begin
                  h_pop   = 1'b1;
                  state_d = hist_top;
                  if (step_q != '0) step_d = step_q - STEP_W'(1);
               end
            end
            default: ;
         endcase
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q <= '0;
         step_q  <= '0;
      end else begin
         state_q <= state_d;
         step_q  <= step_d;
      end
   end

   state_history #(
      .DEPTH (HIST_DEPTH),
      .W     (STATE_W)
   ) u_hist (
      .clk         (clk),
      .reset       (reset),
      .push_i      (h_push),
      .pop_i       (h_pop),
      .clear_i     (h_clear),
      .push_data_i (state_q),
      .top_data_o  (hist_top),
      .count_o     (hist_count)
   );

   assign game_state = state_q;
   assign step_count = step_q;

endmodule
